// File: rtl/irq_pkg.sv
// Shared types and widths for the interrupt arbiter.
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StWaitAck,
    StGap
  } state_e;

  localparam int unsigned HoldW = 8;
  localparam int unsigned GapW  = 4;

  // Index width, never below one bit so a two-source build still has an id port.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner picker: first set eligible bit at or after start_i, wrapping.
module irq_prio_sel #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IdW   = 2
) (
  input  logic [N_SRC-1:0] eligible_i,
  input  logic [IdW-1:0]   start_i,
  output logic [N_SRC-1:0] grant_o,
  output logic [IdW-1:0]   idx_o
);

  always_comb begin
    int unsigned k;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      k = (32'(start_i) + i) % N_SRC;
      if (!found && eligible_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IdW'(k);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latching interrupt arbiter with minimum hold, ack handshake and forced gap.
// Define IRQ_ARBITER_RR_EN for round-robin selection; default is lowest index wins.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned HOLD_CYCLES = 63,
  parameter int unsigned GAP_CYCLES  = 2,
  localparam int unsigned IdW        = id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             irq_ack,
  output logic             irq_out,
  output logic [IdW-1:0]   irq_id,
  output logic [N_SRC-1:0] irq_pending
);

  state_e             state_q, state_d;
  logic               out_q, out_d;
  logic               ack_seen_q, ack_seen_d;
  logic               armed_q;
  logic [IdW-1:0]     id_q, id_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [N_SRC-1:0]   in_q, pending_q, pending_d;
  logic [N_SRC-1:0]   rise, clr, eligible, sel_grant;
  logic [IdW-1:0]     sel_idx, start_idx;

  // armed_q gates the first post-reset cycle so a level already high is not taken as an edge.
  assign rise      = irq_in & ~in_q & {N_SRC{armed_q}};
  assign eligible  = pending_q & ~irq_mask;
  assign pending_d = (pending_q & ~clr) | rise;

`ifdef IRQ_ARBITER_RR_EN
  logic [IdW-1:0] rr_q, rr_d;
  assign start_idx = (rr_q == IdW'(N_SRC - 1)) ? '0 : rr_q + 1'b1;
`else
  assign start_idx = '0;
`endif

  irq_prio_sel #(
    .N_SRC (N_SRC),
    .IdW   (IdW)
  ) u_sel (
    .eligible_i (eligible),
    .start_i    (start_idx),
    .grant_o    (sel_grant),
    .idx_o      (sel_idx)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    ack_seen_d = ack_seen_q;
    id_d       = id_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    clr        = '0;
`ifdef IRQ_ARBITER_RR_EN
    rr_d       = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|sel_grant) begin
          state_d    = StAssert;
          out_d      = 1'b1;
          id_d       = sel_idx;
          hold_d     = HoldW'(HOLD_CYCLES - 1);
          ack_seen_d = 1'b0;
`ifdef IRQ_ARBITER_RR_EN
          rr_d       = sel_idx;
`endif
        end
      end
      StAssert: begin
        if (irq_ack) ack_seen_d = 1'b1;
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (ack_seen_q || irq_ack) begin
          state_d    = StGap;
          out_d      = 1'b0;
          gap_d      = GapW'(GAP_CYCLES - 1);
          clr        = N_SRC'(1) << id_q;
          ack_seen_d = 1'b0;
        end else begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (irq_ack) begin
          state_d    = StGap;
          out_d      = 1'b0;
          gap_d      = GapW'(GAP_CYCLES - 1);
          clr        = N_SRC'(1) << id_q;
          ack_seen_d = 1'b0;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      out_q      <= 1'b0;
      ack_seen_q <= 1'b0;
      armed_q    <= 1'b0;
      id_q       <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
      in_q       <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      ack_seen_q <= ack_seen_d;
      armed_q    <= 1'b1;
      id_q       <= id_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      in_q       <= irq_in;
      pending_q  <= pending_d;
    end
  end

`ifdef IRQ_ARBITER_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  assign irq_out     = out_q;
  assign irq_id      = id_q;
  assign irq_pending = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter (N_SRC=4, HOLD_CYCLES=4, GAP_CYCLES=2).
module tb_irq_arbiter;

  localparam int NS   = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] irq_in, irq_mask, irq_pending;
  logic          irq_ack, irq_out;
  logic [1:0]    irq_id;

  irq_arbiter #(
    .N_SRC       (NS),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .irq_mask    (irq_mask),
    .irq_ack     (irq_ack),
    .irq_out     (irq_out),
    .irq_id      (irq_id),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks how long the line has been high / low rather than FSM state.
  logic [NS-1:0] m_pend, m_prev;
  bit            m_out, m_armed, m_acked;
  int            m_id, m_high, m_gap, m_last;

  function automatic void model_reset();
    m_pend = '0; m_prev = '0; m_out = 0; m_armed = 0; m_acked = 0;
    m_id = 0; m_high = 0; m_gap = 0; m_last = 0;
  endfunction

  function automatic int pick(input logic [NS-1:0] elig);
    for (int k = 0; k < NS; k++) begin
      int idx;
`ifdef IRQ_ARBITER_RR_EN
      idx = (m_last + 1 + k) % NS;
`else
      idx = k;
`endif
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [NS-1:0] in, input logic [NS-1:0] mask,
                                     input logic ack);
    logic [NS-1:0] rise, clr;
    int w;
    rise = m_armed ? (in & ~m_prev) : '0;
    clr  = '0;
    if (m_out) begin
      if (m_high >= HOLD && (m_acked || ack)) begin
        m_out = 0;
        clr[m_id] = 1'b1;
        m_gap = GAP;
      end else begin
        m_high++;
        m_acked = m_acked || ack;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = pick(m_pend & ~mask);
      if (w >= 0) begin
        m_out = 1; m_id = w; m_high = 1; m_acked = 0; m_last = w;
      end
    end
    m_pend  = (m_pend & ~clr) | rise;
    m_prev  = in;
    m_armed = 1;
  endfunction

  task automatic step(input logic [NS-1:0] in, input logic [NS-1:0] mask, input logic ack);
    irq_in = in; irq_mask = mask; irq_ack = ack;
    model_step(in, mask, ack);
    @(posedge clk);
    #1;
    check("irq_out", irq_out, m_out);
    check("irq_id", irq_id, m_id);
    check("irq_pending", irq_pending, m_pend);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out", irq_out, 0);
    check("rst_id", irq_id, 0);
    check("rst_pending", irq_pending, 0);
  endtask

  typedef struct {
    logic [NS-1:0] in;
    logic [NS-1:0] mask;
    logic          ack;
    logic          e_out;
    logic [1:0]    e_id;
    logic [NS-1:0] e_pend;
  } vec_t;

  vec_t tbl[19];
  int   got[$];
  int   hi;
  logic prev_out;
  logic [NS-1:0] rin, rmask;

  initial begin
    irq_in = '0; irq_mask = '0; irq_ack = 1'b0;
    do_reset();

    // Single grant with early ack, then a masked edge released later.
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0100};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[10] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 2'd2, 4'b0100};
    tbl[11] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 2'd2, 4'b0100};
    tbl[12] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[13] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[14] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[15] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[16] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].in, tbl[i].mask, tbl[i].ack);
      check($sformatf("tbl%0d_out", i), irq_out, tbl[i].e_out);
      check($sformatf("tbl%0d_id", i), irq_id, tbl[i].e_id);
      check($sformatf("tbl%0d_pend", i), irq_pending, tbl[i].e_pend);
    end

    // Simultaneous edges on sources 0 and 3, pointer fresh from reset.
    do_reset();
    step('0, '0, 1'b0);
    prev_out = irq_out;
    for (int c = 0; c < 60 && got.size() < 2; c++) begin
      step(4'b1001, '0, 1'b1);
      if (irq_out && !prev_out) got.push_back(int'(irq_id));
      prev_out = irq_out;
    end
    check("grant_count", got.size(), 2);
    if (got.size() >= 2) begin
`ifdef IRQ_ARBITER_RR_EN
      check("order_first", got[0], 3);
      check("order_second", got[1], 0);
`else
      check("order_first", got[0], 0);
      check("order_second", got[1], 3);
`endif
    end
    for (int c = 0; c < 10; c++) step('0, '0, 1'b1);

    // Grant on source 1 with the ack held off for ten high cycles.
    hi = 0;
    step(4'b0010, '0, 1'b0);
    for (int c = 0; c < 5 && !irq_out; c++) step(4'b0010, '0, 1'b0);
    if (irq_out) hi = 1;
    for (int c = 0; c < 10; c++) begin
      step(4'b0010, '0, 1'b0);
      if (irq_out) hi++;
    end
    step(4'b0010, '0, 1'b1);
    if (irq_out) hi++;
    check("late_ack_high_len", hi, 11);
    check("late_ack_pend1", irq_pending[1], 0);
    for (int c = 0; c < 5; c++) step('0, '0, 1'b0);

    // New edge on the granted source in the cycle that enters the gap.
    step(4'b0100, '0, 1'b0);
    for (int c = 0; c < 5 && !irq_out; c++) step(4'b0100, '0, 1'b0);
    check("regrant_first_out", irq_out, 1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step(4'b0100, '0, 1'b0);
    check("gap_entry_out", irq_out, 0);
    check("gap_entry_pend2", irq_pending[2], 1);
    for (int c = 0; c < 10 && !irq_out; c++) step(4'b0100, '0, 1'b0);
    check("regrant_out", irq_out, 1);
    check("regrant_id", irq_id, 2);

    // Asynchronous reset in the middle of the hold window, input level held high.
    #2;
    irq_in = 4'b1111;
    rst = 1'b1;
    #1;
    check("async_rst_out", irq_out, 0);
    do_reset();
    for (int c = 0; c < 5; c++) step(4'b1111, '0, 1'b0);
    check("held_level_no_edge", irq_pending, 0);

    // Randomized traffic against the model.
    rin = 4'b1111; rmask = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 7) == 0) rin[b] = ~rin[b];
      if ($urandom_range(0, 31) == 0) rmask = NS'($urandom);
      step(rin, rmask, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
